// File: rtl/muldiv_sched.sv
// Multiply/divide scheduler: sequences one mult/div from EX through an external
// multiplier/divider into HI/LO. Optional macro: MD_DIVZERO_BYPASS_EN.
module muldiv_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  input  logic        pipe_hold,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] result_q, result_nxt;
  logic        div_zero;

`ifdef MD_DIVZERO_BYPASS_EN
  assign div_zero = (src_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      result_q <= result_nxt;
    end
  end

  // All outputs are qualified by resetn so they drop the instant reset asserts.
  always_comb begin
    state_nxt   = state;
    result_nxt  = result_q;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_annul   = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    stallreq    = 1'b0;
    busy        = 1'b0;
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;
    if (resetn) begin
      busy = (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          stallreq = op_valid;
          if (op_valid && !annul) begin
            if (!op_sel[1]) begin
              mul_signed = (op_sel == 2'b00);
              mul_ina    = src_a;
              mul_inb    = src_b;
              state_nxt  = S_MUL;
            end else if (div_zero) begin
              result_nxt = {src_a, 32'hFFFF_FFFF};
              state_nxt  = S_DONE;
            end else begin
              div_start   = 1'b1;
              div_signed  = (op_sel == 2'b10);
              div_opdata1 = src_a;
              div_opdata2 = src_b;
              state_nxt   = S_DIV;
            end
          end
        end
        S_MUL: begin
          stallreq   = op_valid;
          mul_signed = (op_sel == 2'b00);
          mul_ina    = src_a;
          mul_inb    = src_b;
          if (annul) begin
            state_nxt = S_IDLE;
          end else begin
            result_nxt = mul_result;
            state_nxt  = S_DONE;
          end
        end
        S_DIV: begin
          stallreq    = op_valid;
          div_signed  = (op_sel == 2'b10);
          div_opdata1 = src_a;
          div_opdata2 = src_b;
          // annul wins over a coincident div_ready; the divider result is dropped
          if (annul) begin
            div_annul = 1'b1;
            state_nxt = S_IDLE;
          end else if (div_ready) begin
            result_nxt = div_result;
            state_nxt  = S_DONE;
          end else begin
            div_start = 1'b1;
          end
        end
        S_DONE: begin
          if (annul) begin
            state_nxt = S_IDLE;
          end else if (!pipe_hold) begin
            hilo_we   = 1'b1;
            hi_wdata  = result_q[63:32];
            lo_wdata  = result_q[31:0];
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
